fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the 16-bit WISC-SP22 pipeline, placed directly upstream of the IF/ID pipeline register. It owns the PC and issues reads to a multi-cycle instruction memory with a request/done handshake. It presents each fetched instruction with its PC+2 to IF/ID. It handles hazard stalls, branch/jump redirects (flushes) and HALT.

## Interface
- RESET_PC, 16'h0000, PC value loaded at reset
- NOP_INSTR, 16'h0800, instruction word driven on bubbles and flushes
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-low reset: sampled on the rising edge of clk, 0 = reset
- stall_in  input  1  hazard stall from decode; 1 = downstream cannot accept a new instruction
- redirect  input  1  branch/jump taken; flush and refetch from redirect_pc
- redirect_pc  input  16  target address, valid while redirect=1
- imem_addr  output  16  read address; always equals the PC register
- imem_rd  output  1  read request; combinational, 1 only in state FETCH while rst=1 and redirect=0
- imem_data  input  16  read data; valid only while imem_done=1
- imem_done  input  1  read complete; may assert in the request cycle (hit) or any later cycle
- instruction_out  output  16  instruction to IF/ID (registered)
- pc_plus_two_out  output  16  address of fetched instruction + 2 (registered)
- valid_out  output  1  1 = instruction_out is a real fetched instruction
- halted  output  1  1 = a HALT (opcode 5'b00000) has been issued and fetch has stopped

## Operation
- States:
  - FETCH: request issued this cycle.
  - WAIT: request outstanding.
  - HOLD: instruction captured but stalled.
  - DRAIN: outstanding request must be discarded.
  - HALTED.
- Reset (rst=0 at the edge):
  - pc=RESET_PC, state=FETCH.
  - instruction_out=NOP_INSTR, pc_plus_two_out=16'h0000, valid_out=0, halted=0, hold buffer cleared.
  - Reset overrides everything, including mid-WAIT. Memory-side cancellation is the memory's responsibility.
- Priority at each edge: reset > redirect > capture/stall > idle.
- Capture is the event (FETCH or WAIT) and imem_done=1:
  - stall_in=0: instruction_out=imem_data, pc_plus_two_out=pc+2, valid_out=1.
    - If imem_data[15:11]==5'b00000: pc is unchanged and next state is HALTED.
    - Otherwise pc=pc+2 and next state is FETCH.
  - stall_in=1: imem_data is stored in the hold buffer and next state is HOLD. Outputs and pc are unchanged.
- FETCH with imem_done=0: next state is WAIT; imem_rd drops.
- HOLD:
  - While stall_in=1: outputs and pc are held.
  - First cycle with stall_in=0: the buffered word issues exactly as a capture, including the HALT check.
- No capture and stall_in=0 (WAIT, DRAIN, HALTED): instruction_out=NOP_INSTR and valid_out=0 (bubble). pc_plus_two_out holds.
- No capture and stall_in=1: all outputs hold.
- Redirect=1:
  - pc=redirect_pc, instruction_out=NOP_INSTR, valid_out=0, hold buffer discarded, halted=0.
  - Next state is DRAIN if a request is outstanding and not completing this cycle (state WAIT with imem_done=0). Otherwise next state is FETCH.
  - Redirect overrides stall_in.
- DRAIN: imem_done is ignored (data dropped); go to FETCH the cycle after done is seen. A redirect during DRAIN updates pc and stays in DRAIN.
- HALTED: imem_rd=0 and halted=1. Only redirect or reset exits.
- Arithmetic: pc+2 is a 16-bit add with wraparound (16'hFFFE+2 = 16'h0000). redirect_pc bit 0 is used as given.

## Timing
- Fetch hit latency: request in cycle N with imem_done=1 puts the instruction on the outputs in cycle N+1. Next request is in cycle N+1, giving a throughput of 1 instruction/cycle.
- Miss: done in cycle N+k presents the instruction in N+k+1. imem_rd is high only in the first request cycle.
- Stall release from HOLD: the instruction appears the cycle after stall_in falls. The next request is issued in that same cycle.
- Redirect in cycle N: imem_addr=redirect_pc in N+1, plus DRAIN cycles if a request is outstanding.
- halted rises the cycle the HALT instruction appears on the outputs.

## Test plan
- Reset then 3 hits at 0x0000/0x0002/0x0004 (data 0x4001, 0x4002, 0x4003): each is output the cycle after its request with pc_plus_two_out 0x0002, 0x0004, 0x0006 and valid_out=1 throughout.
- Miss with done 3 cycles after the request: 3 NOP bubbles with valid_out=0, then the instruction; imem_rd is high for 1 cycle only.
- stall_in high for 2 cycles across a hit: outputs are frozen, the word is buffered, it issues the cycle stall falls, and the PC advances only once.
- redirect to 0x0100 while in WAIT: NOP/valid 0; the late done data is dropped; the next request is at 0x0100 after done; no stale instruction ever has valid_out=1.
- Fetch 0x0000 (HALT) at pc 0x0010: halted=1, imem_rd stays 0 for 10 cycles, pc_plus_two_out=0x0012; a redirect to 0x0020 resumes fetch and clears halted.
- rst=0 asserted mid-WAIT and at pc 0xFFFE: pc returns to RESET_PC and all outputs take reset values; separately, a hit at 0xFFFE gives pc_plus_two_out=0x0000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a request/done instruction memory
// and hands each fetched word plus PC+2 to IF/ID, with stall, redirect and HALT handling.
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] imem_addr,
  output logic        imem_rd,
  input  logic [15:0] imem_data,
  input  logic        imem_done,
  output logic [15:0] instruction_out,
  output logic [15:0] pc_plus_two_out,
  output logic        valid_out,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_WAIT   = 3'd1,
    S_HOLD   = 3'd2,
    S_DRAIN  = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] ppt_q, ppt_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic [15:0] hold_q, hold_d;

  logic [15:0] pc_inc;
  logic [15:0] issue_word;
  logic        capture;
  logic        issue;

  assign pc_inc     = pc_q + 16'd2;
  assign capture    = ((state_q == S_FETCH) || (state_q == S_WAIT)) && imem_done;
  // A buffered word in HOLD leaves exactly like a fresh capture once the stall clears.
  assign issue      = !stall_in && (capture || (state_q == S_HOLD));
  assign issue_word = (state_q == S_HOLD) ? hold_q : imem_data;

  assign imem_addr       = pc_q;
  assign imem_rd         = (state_q == S_FETCH) && rst && !redirect;
  assign instruction_out = instr_q;
  assign pc_plus_two_out = ppt_q;
  assign valid_out       = valid_q;
  assign halted          = halted_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    ppt_d    = ppt_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    hold_d   = hold_q;

    if (redirect) begin
      pc_d     = redirect_pc;
      instr_d  = NOP_INSTR;
      valid_d  = 1'b0;
      halted_d = 1'b0;
      hold_d   = NOP_INSTR;
      // Any request still in flight after this edge must have its data thrown away.
      if (((state_q == S_WAIT) || (state_q == S_DRAIN)) && !imem_done) begin
        state_d = S_DRAIN;
      end else begin
        state_d = S_FETCH;
      end
    end else if (issue) begin
      instr_d = issue_word;
      ppt_d   = pc_inc;
      valid_d = 1'b1;
      if (issue_word[15:11] == 5'b00000) begin
        halted_d = 1'b1;
        state_d  = S_HALTED;
      end else begin
        pc_d    = pc_inc;
        state_d = S_FETCH;
      end
    end else if (capture) begin
      hold_d  = imem_data;
      state_d = S_HOLD;
    end else begin
      case (state_q)
        S_FETCH: state_d = S_WAIT;
        S_DRAIN: if (imem_done) state_d = S_FETCH;
        default: state_d = state_q;
      endcase
      if (!stall_in) begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      instr_q  <= NOP_INSTR;
      ppt_q    <= 16'h0000;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      hold_q   <= NOP_INSTR;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      ppt_q    <= ppt_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      hold_q   <= hold_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a vector table walks hits, miss, stall, redirect-drain
// and HALT; hand sequences cover the halted dwell, resume, reset mid-WAIT and PC wrap.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, stall_in, redirect, imem_done;
  logic [15:0] redirect_pc, imem_data;
  logic [15:0] imem_addr, instruction_out, pc_plus_two_out;
  logic        imem_rd, valid_out, halted;

  int checks   = 0;
  int failures = 0;
  int step_no  = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .stall_in       (stall_in),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rd        (imem_rd),
    .imem_data      (imem_data),
    .imem_done      (imem_done),
    .instruction_out(instruction_out),
    .pc_plus_two_out(pc_plus_two_out),
    .valid_out      (valid_out),
    .halted         (halted)
  );

  typedef struct packed {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [15:0] rpc;
    logic        done;
    logic [15:0] data;
    logic        chk_comb;
    logic [15:0] e_addr;
    logic        e_rd;
    logic [15:0] e_instr;
    logic [15:0] e_ppt;
    logic        e_valid;
    logic        e_halt;
  } vec_t;

  function automatic vec_t mk(
    input logic r, input logic s, input logic rd_, input logic [15:0] rpc,
    input logic dn, input logic [15:0] dat, input logic cc,
    input logic [15:0] ea, input logic er, input logic [15:0] ei,
    input logic [15:0] ep, input logic ev, input logic eh);
    vec_t v;
    v.rst = r; v.stall = s; v.redir = rd_; v.rpc = rpc; v.done = dn; v.data = dat;
    v.chk_comb = cc; v.e_addr = ea; v.e_rd = er; v.e_instr = ei; v.e_ppt = ep;
    v.e_valid = ev; v.e_halt = eh;
    return v;
  endfunction

  task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s step=%0d got=%h want=%h", name, step_no, got, want);
    end
  endtask

  // Inputs change at the falling edge; comb outputs are sampled before the rising
  // edge and registered outputs 1 time unit after it.
  task automatic apply(input vec_t v);
    @(negedge clk);
    rst = v.rst; stall_in = v.stall; redirect = v.redir; redirect_pc = v.rpc;
    imem_done = v.done; imem_data = v.data;
    #1;
    if (v.chk_comb) begin
      chk16("imem_addr", imem_addr, v.e_addr);
      chk16("imem_rd", {15'd0, imem_rd}, {15'd0, v.e_rd});
    end
    @(posedge clk);
    #1;
    chk16("instruction_out", instruction_out, v.e_instr);
    chk16("pc_plus_two_out", pc_plus_two_out, v.e_ppt);
    chk16("valid_out", {15'd0, valid_out}, {15'd0, v.e_valid});
    chk16("halted", {15'd0, halted}, {15'd0, v.e_halt});
    $display("step %0d addr=%h rd=%b instr=%h ppt=%h valid=%b halted=%b",
             step_no, imem_addr, imem_rd, instruction_out, pc_plus_two_out, valid_out, halted);
    step_no++;
  endtask

  localparam logic [15:0] NOP = 16'h0800;

  vec_t tbl[18];

  initial begin
    rst = 1'b0; stall_in = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
    imem_done = 1'b0; imem_data = 16'h0;

    //             rst stl red rpc       dn  data      cc  addr      rd  instr     ppt       v   h
    tbl[0]  = mk(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, NOP,      16'h0000, 0, 0);
    // three back-to-back hits
    tbl[1]  = mk(1, 0, 0, 16'h0000, 1, 16'h4001, 1, 16'h0000, 1, 16'h4001, 16'h0002, 1, 0);
    tbl[2]  = mk(1, 0, 0, 16'h0000, 1, 16'h4002, 1, 16'h0002, 1, 16'h4002, 16'h0004, 1, 0);
    tbl[3]  = mk(1, 0, 0, 16'h0000, 1, 16'h4003, 1, 16'h0004, 1, 16'h4003, 16'h0006, 1, 0);
    // miss: done three cycles after the request
    tbl[4]  = mk(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0006, 1, NOP,      16'h0006, 0, 0);
    tbl[5]  = mk(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0006, 0, NOP,      16'h0006, 0, 0);
    tbl[6]  = mk(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0006, 0, NOP,      16'h0006, 0, 0);
    tbl[7]  = mk(1, 0, 0, 16'h0000, 1, 16'h4004, 1, 16'h0006, 0, 16'h4004, 16'h0008, 1, 0);
    // stall held two cycles across a hit
    tbl[8]  = mk(1, 1, 0, 16'h0000, 1, 16'h4005, 1, 16'h0008, 1, 16'h4004, 16'h0008, 1, 0);
    tbl[9]  = mk(1, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0008, 0, 16'h4004, 16'h0008, 1, 0);
    tbl[10] = mk(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0008, 0, 16'h4005, 16'h000A, 1, 0);
    // redirect while WAIT, late done is dropped
    tbl[11] = mk(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h000A, 1, NOP,      16'h000A, 0, 0);
    tbl[12] = mk(1, 0, 1, 16'h0100, 0, 16'h0000, 1, 16'h000A, 0, NOP,      16'h000A, 0, 0);
    tbl[13] = mk(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0100, 0, NOP,      16'h000A, 0, 0);
    tbl[14] = mk(1, 0, 0, 16'h0000, 1, 16'h4EEE, 1, 16'h0100, 0, NOP,      16'h000A, 0, 0);
    tbl[15] = mk(1, 0, 0, 16'h0000, 1, 16'h4006, 1, 16'h0100, 1, 16'h4006, 16'h0102, 1, 0);
    // HALT fetched at 0x0010
    tbl[16] = mk(1, 0, 1, 16'h0010, 0, 16'h0000, 1, 16'h0102, 0, NOP,      16'h0102, 0, 0);
    tbl[17] = mk(1, 0, 0, 16'h0000, 1, 16'h0000, 1, 16'h0010, 1, 16'h0000, 16'h0012, 1, 1);

    for (int i = 0; i < 18; i++) apply(tbl[i]);

    // halted dwell: no requests, bubble out, halted stays high
    for (int i = 0; i < 10; i++)
      apply(mk(1, 0, 0, 16'h0000, 1, 16'h4BAD, 1, 16'h0010, 0, NOP, 16'h0012, 0, 1));
    apply(mk(1, 0, 1, 16'h0020, 0, 16'h0000, 1, 16'h0010, 0, NOP,      16'h0012, 0, 0));
    apply(mk(1, 0, 0, 16'h0000, 1, 16'h4007, 1, 16'h0020, 1, 16'h4007, 16'h0022, 1, 0));

    // reset mid-WAIT at pc 0xFFFE
    apply(mk(1, 0, 1, 16'hFFFE, 0, 16'h0000, 1, 16'h0022, 0, NOP,      16'h0022, 0, 0));
    apply(mk(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'hFFFE, 1, NOP,      16'h0022, 0, 0));
    apply(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'hFFFE, 0, NOP,      16'h0000, 0, 0));
    apply(mk(1, 0, 0, 16'h0000, 1, 16'h4009, 1, 16'h0000, 1, 16'h4009, 16'h0002, 1, 0));

    // hit at 0xFFFE wraps PC+2 to 0x0000
    apply(mk(1, 0, 1, 16'hFFFE, 0, 16'h0000, 1, 16'h0002, 0, NOP,      16'h0002, 0, 0));
    apply(mk(1, 0, 0, 16'h0000, 1, 16'h400A, 1, 16'hFFFE, 1, 16'h400A, 16'h0000, 1, 0));
    apply(mk(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 1, NOP,      16'h0000, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
